// File: rtl/rvc_pkg.sv
// Shared definitions for the RV32C fetch/align slice.
// Contents: fetch FSM state type, opcode marker for 32-bit encodings,
// halfword width and halfword queue depth.
package rvc_pkg;

  localparam logic [1:0]  OPC_32 = 2'b11;
  localparam int unsigned HW_W   = 16;
  localparam int unsigned QDEPTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_KILL = 2'd2
  } state_e;

endpackage

// File: rtl/rvc_fetch_align_if.sv
// Bus bundle between rvc_fetch_align and its environment.
//   redirect : iREDIRECT, iREDIRECT_PC
//   memory   : oMEM_REQ, oMEM_ADDR, iMEM_VALID, iMEM_DATA
//   decode   : oIR_VALID, iIR_READY, oIR, oIR_IS_C, oIR_PC, oIR_ILLEGAL
// master = fetch unit side, slave = environment (RAM, decoder, branch unit).
interface rvc_fetch_align_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              iREDIRECT;
  logic [31:0]       iREDIRECT_PC;
  logic              oMEM_REQ;
  logic [ADDR_W-1:0] oMEM_ADDR;
  logic              iMEM_VALID;
  logic [31:0]       iMEM_DATA;
  logic              oIR_VALID;
  logic              iIR_READY;
  logic [31:0]       oIR;
  logic              oIR_IS_C;
  logic [31:0]       oIR_PC;
  logic              oIR_ILLEGAL;

  modport master (
    input  iREDIRECT, iREDIRECT_PC, iMEM_VALID, iMEM_DATA, iIR_READY,
    output oMEM_REQ, oMEM_ADDR, oIR_VALID, oIR, oIR_IS_C, oIR_PC, oIR_ILLEGAL
  );

  modport slave (
    output iREDIRECT, iREDIRECT_PC, iMEM_VALID, iMEM_DATA, iIR_READY,
    input  oMEM_REQ, oMEM_ADDR, oIR_VALID, oIR, oIR_IS_C, oIR_PC, oIR_ILLEGAL
  );
endinterface

// File: rtl/rvc_halfword_queue.sv
// Four-entry halfword shift queue feeding the aligner.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   flush      : empty the queue (count -> 0)
//   push_n     : halfwords appended this cycle (0..2), taken from push_hw[15:0] first
//   push_hw    : halfwords to append
//   pop_n      : halfwords removed from the head this cycle (0..2)
//   count      : valid entries (0..4)
//   head0/1    : two oldest entries
module rvc_halfword_queue
  import rvc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [1:0]        push_n,
  input  logic [2*HW_W-1:0] push_hw,
  input  logic [1:0]        pop_n,
  output logic [2:0]        count,
  output logic [HW_W-1:0]   head0,
  output logic [HW_W-1:0]   head1
);

  logic [HW_W-1:0] q_q [QDEPTH];
  logic [HW_W-1:0] q_d [QDEPTH];
  logic [2:0]      count_q, count_d;
  logic [2:0]      base;
  logic [2:0]      src;
  logic [2:0]      dst;

  // Pop is applied first (shift down), then new halfwords land right after
  // the surviving entries, so push and pop can share a cycle.
  always_comb begin
    base = count_q - {1'b0, pop_n};
    src  = '0;
    dst  = '0;
    for (int unsigned i = 0; i < QDEPTH; i++) begin
      src    = 3'(i) + {1'b0, pop_n};
      q_d[i] = (src < 3'(QDEPTH)) ? q_q[src[1:0]] : '0;
    end
    for (int unsigned j = 0; j < 2; j++) begin
      dst = base + 3'(j);
      if (3'(j) < {1'b0, push_n}) begin
        q_d[dst[1:0]] = push_hw[j*HW_W +: HW_W];
      end
    end
    count_d = flush ? '0 : base + {1'b0, push_n};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) q_q[i] <= '0;
    end else begin
      count_q <= count_d;
      for (int unsigned i = 0; i < QDEPTH; i++) q_q[i] <= q_d[i];
    end
  end

  assign count = count_q;
  assign head0 = q_q[0];
  assign head1 = q_q[1];

endmodule

// File: rtl/rvc_fetch_align.sv
// RV32C fetch/align front end: fetches 32-bit words from instruction RAM,
// buffers them as halfwords and presents one aligned 16- or 32-bit
// instruction per handshake, including 32-bit instructions split across
// words and redirects to halfword-aligned targets.
// Ports:
//   iCLK, iRST_N : clock, async active-low reset
//   bus          : rvc_fetch_align_if.master (redirect, RAM request/response,
//                  instruction valid/ready/data/is_c/pc/illegal)
// Parameters: RESET_PC (byte PC after reset), ADDR_W (RAM word-address width)
// Build option: RVC_ILLEGAL_EN flags a 16'h0000 halfword at the head on
// oIR_ILLEGAL; without it oIR_ILLEGAL is tied low.
module rvc_fetch_align
  import rvc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 8
) (
  input  logic                 iCLK,
  input  logic                 iRST_N,
  rvc_fetch_align_if.master    bus
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        discard_lo_q, discard_lo_d;
  logic        run_q, run_d;

  logic [2:0]      count;
  logic [HW_W-1:0] head0, head1;
  logic            is_c;
  logic            ir_valid;
  logic            fire;
  logic            mem_req;
  logic            push;
  logic [1:0]      push_n;
  logic [1:0]      pop_n;
  logic [31:0]     push_hw;

  rvc_halfword_queue u_queue (
    .clk     (iCLK),
    .rst_n   (iRST_N),
    .flush   (bus.iREDIRECT),
    .push_n  (push_n),
    .push_hw (push_hw),
    .pop_n   (pop_n),
    .count   (count),
    .head0   (head0),
    .head1   (head1)
  );

  // Handshake decode. run_q keeps oMEM_REQ low while reset is held and
  // for the first edge after release.
  always_comb begin
    is_c     = (head0[1:0] != OPC_32);
    ir_valid = ((count >= 3'd1) && is_c) || (count >= 3'd2);
    fire     = ir_valid && bus.iIR_READY && !bus.iREDIRECT;
    mem_req  = run_q && (state_q == S_IDLE) && (count <= 3'd2) && !bus.iREDIRECT;
    push     = (state_q == S_WAIT) && bus.iMEM_VALID && !bus.iREDIRECT;
    pop_n    = fire ? (is_c ? 2'd1 : 2'd2) : 2'd0;
    push_n   = push ? (discard_lo_q ? 2'd1 : 2'd2) : 2'd0;
    push_hw  = discard_lo_q ? {bus.iMEM_DATA[31:16], bus.iMEM_DATA[31:16]}
                            : bus.iMEM_DATA;
  end

  // PC, fetch PC and discard-low flag.
  always_comb begin
    pc_d         = pc_q;
    fetch_pc_d   = fetch_pc_q;
    discard_lo_d = discard_lo_q;
    run_d        = 1'b1;
    if (bus.iREDIRECT) begin
      pc_d         = bus.iREDIRECT_PC & ~32'd1;
      fetch_pc_d   = bus.iREDIRECT_PC & ~32'd3;
      discard_lo_d = bus.iREDIRECT_PC[1];
    end else begin
      if (fire) pc_d = pc_q + (is_c ? 32'd2 : 32'd4);
      if (push) begin
        fetch_pc_d   = fetch_pc_q + 32'd4;
        discard_lo_d = 1'b0;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      pc_q         <= RESET_PC;
      fetch_pc_q   <= RESET_PC;
      discard_lo_q <= 1'b0;
      run_q        <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      fetch_pc_q   <= fetch_pc_d;
      discard_lo_q <= discard_lo_d;
      run_q        <= run_d;
    end
  end

  // FSM: state register
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // FSM: next state. A redirect with a request in flight parks in S_KILL
  // so the stale response is swallowed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (mem_req) state_d = S_WAIT;
      S_WAIT: begin
        if (bus.iREDIRECT)       state_d = bus.iMEM_VALID ? S_IDLE : S_KILL;
        else if (bus.iMEM_VALID) state_d = S_IDLE;
      end
      S_KILL: if (bus.iMEM_VALID) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM / datapath outputs
  always_comb begin
    bus.oMEM_REQ  = mem_req;
    bus.oMEM_ADDR = fetch_pc_q[ADDR_W+1:2];
    bus.oIR_VALID = ir_valid;
    bus.oIR       = is_c ? {16'h0000, head0} : {head1, head0};
    bus.oIR_IS_C  = ir_valid && is_c;
    bus.oIR_PC    = pc_q;
`ifdef RVC_ILLEGAL_EN
    bus.oIR_ILLEGAL = ir_valid && is_c && (head0 == '0);
`else
    bus.oIR_ILLEGAL = 1'b0;
`endif
  end

endmodule

// File: tb/tb_rvc_fetch_align.sv
// Directed bench for rvc_fetch_align with a RAM responder and an
// expected-instruction queue checked on every accepted instruction.
module tb_rvc_fetch_align;

  typedef struct packed {
    logic [31:0] ir;
    logic        is_c;
    logic [31:0] pc;
    logic        ill;
  } exp_t;

`ifdef RVC_ILLEGAL_EN
  localparam logic ILL_EXP = 1'b1;
`else
  localparam logic ILL_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  logic [31:0] mem     [256];
  int unsigned mem_dly [256];
  exp_t        sb[$];

  rvc_fetch_align_if #(.ADDR_W(8)) bus ();

  rvc_fetch_align #(
    .RESET_PC (32'h0000_0000),
    .ADDR_W   (8)
  ) dut (
    .iCLK   (clk),
    .iRST_N (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // RAM: request seen at a falling edge, answered after mem_dly[addr] extra cycles.
  initial begin : responder
    logic        pend;
    logic [7:0]  pend_addr;
    int unsigned pend_dly;
    pend = 1'b0; pend_addr = '0; pend_dly = 0;
    bus.iMEM_VALID = 1'b0;
    bus.iMEM_DATA  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) pend = 1'b0;
      else if (bus.oMEM_REQ) begin
        pend      = 1'b1;
        pend_addr = bus.oMEM_ADDR;
        pend_dly  = mem_dly[pend_addr];
      end
      @(posedge clk);
      #1;
      bus.iMEM_VALID = 1'b0;
      if (pend && rst_n) begin
        if (pend_dly == 0) begin
          bus.iMEM_VALID = 1'b1;
          bus.iMEM_DATA  = mem[pend_addr];
          pend = 1'b0;
        end else begin
          pend_dly--;
        end
      end
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && bus.oIR_VALID && bus.iIR_READY) begin
      check("fire_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("ir",      bus.oIR,               e.ir);
        check("is_c",    32'(bus.oIR_IS_C),     32'(e.is_c));
        check("ir_pc",   bus.oIR_PC,            e.pc);
        check("illegal", 32'(bus.oIR_ILLEGAL),  32'(e.ill));
      end
    end
  end

  task automatic expect_ir(input logic [31:0] ir, input logic c, input logic [31:0] pc, input logic ill);
    exp_t e;
    e.ir = ir; e.is_c = c; e.pc = pc; e.ill = ill;
    sb.push_back(e);
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] pc);
    @(posedge clk);
    #1;
    bus.iREDIRECT    = 1'b1;
    bus.iREDIRECT_PC = pc;
    @(posedge clk);
    #1;
    bus.iREDIRECT = 1'b0;
    check("redir_valid_low", 32'(bus.oIR_VALID), 32'd0);
  endtask

  task automatic wait_req(output logic [7:0] addr, output logic ok);
    ok = 1'b0;
    addr = '0;
    for (int unsigned i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.oMEM_REQ) begin
        ok = 1'b1;
        addr = bus.oMEM_ADDR;
        break;
      end
    end
  endtask

  task automatic drain();
    @(posedge clk);
    #1;
    bus.iIR_READY = 1'b1;
    for (int unsigned i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) break;
    end
    bus.iIR_READY = 1'b0;
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_mem_req",  32'(bus.oMEM_REQ),    32'd0);
    check("rst_mem_addr", 32'(bus.oMEM_ADDR),   32'd0);
    check("rst_ir_valid", 32'(bus.oIR_VALID),   32'd0);
    check("rst_ir",       bus.oIR,              32'd0);
    check("rst_is_c",     32'(bus.oIR_IS_C),    32'd0);
    check("rst_illegal",  32'(bus.oIR_ILLEGAL), 32'd0);
    check("rst_ir_pc",    bus.oIR_PC,           32'd0);
  endtask

  initial begin : stim
    logic [7:0] a;
    logic       ok;
    for (int unsigned i = 0; i < 256; i++) begin
      mem[i]     = 32'h0001_0001;
      mem_dly[i] = 0;
    end
    rst_n            = 1'b0;
    bus.iREDIRECT    = 1'b0;
    bus.iREDIRECT_PC = '0;
    bus.iIR_READY    = 1'b0;
    #2;
    check_reset_outputs();

    // 1: two compressed instructions in word 0, then fetch of word 1
    mem[0] = 32'h4501_4108;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    wait_req(a, ok);
    check("t1_req0_seen", 32'(ok), 32'd1);
    check("t1_req0_addr", 32'(a),  32'd0);
    wait_req(a, ok);
    check("t1_req1_seen", 32'(ok), 32'd1);
    check("t1_req1_addr", 32'(a),  32'd1);
    expect_ir(32'h0000_4108, 1'b1, 32'h0, 1'b0);
    expect_ir(32'h0000_4501, 1'b1, 32'h2, 1'b0);
    drain();

    // 2: C, all-zero halfword, then aligned 32-bit
    mem[0] = 32'h0000_4108;
    mem[1] = 32'h0000_0513;
    redirect(32'h0);
    expect_ir(32'h0000_4108, 1'b1, 32'h0, 1'b0);
    expect_ir(32'h0000_0000, 1'b1, 32'h2, ILL_EXP);
    expect_ir(32'h0000_0513, 1'b0, 32'h4, 1'b0);
    drain();

    // 3: 32-bit instruction split across words, second word delayed
    mem[0] = 32'h0513_4108;
    mem[1] = 32'h0001_0000;
    mem_dly[1] = 4;
    redirect(32'h0);
    expect_ir(32'h0000_4108, 1'b1, 32'h0, 1'b0);
    drain();
    check("t3_split_hold0", 32'(bus.oIR_VALID), 32'd0);
    cyc(2);
    check("t3_split_hold1", 32'(bus.oIR_VALID), 32'd0);
    expect_ir(32'h0000_0513, 1'b0, 32'h2, 1'b0);
    drain();
    mem_dly[1] = 0;

    // 4: redirect to a halfword-aligned target
    mem[4] = 32'h4505_0001;
    mem[5] = 32'h0000_0513;
    redirect(32'h0000_0012);
    wait_req(a, ok);
    check("t4_req_seen", 32'(ok), 32'd1);
    check("t4_req_addr", 32'(a),  32'd4);
    expect_ir(32'h0000_4505, 1'b1, 32'h12, 1'b0);
    expect_ir(32'h0000_0513, 1'b0, 32'h14, 1'b0);
    drain();

    // 5: redirect while a request is outstanding; stale data must be dropped
    mem[16] = 32'h0000_0513;
    mem[17] = 32'h0000_0513;
    mem_dly[16] = 3;
    mem[20] = 32'h4108_4501;
    redirect(32'h0000_0040);
    wait_req(a, ok);
    check("t5_req_addr", 32'(a), 32'd16);
    redirect(32'h0000_0050);
    for (int unsigned i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t5_kill_no_req",   32'(bus.oMEM_REQ),  32'd0);
      check("t5_kill_no_valid", 32'(bus.oIR_VALID), 32'd0);
    end
    wait_req(a, ok);
    check("t5_new_req_seen", 32'(ok), 32'd1);
    check("t5_new_req_addr", 32'(a),  32'd20);
    expect_ir(32'h0000_4501, 1'b1, 32'h50, 1'b0);
    expect_ir(32'h0000_4108, 1'b1, 32'h52, 1'b0);
    drain();
    mem_dly[16] = 0;

    // 6: consumer stalls with a full queue, then reset mid-stall
    mem[0] = 32'h0000_0513;
    mem[1] = 32'h0001_0001;
    redirect(32'h0);
    cyc(8);
    for (int unsigned i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t6_no_req",   32'(bus.oMEM_REQ),  32'd0);
      check("t6_valid",    32'(bus.oIR_VALID), 32'd1);
      check("t6_ir_hold",  bus.oIR,            32'h0000_0513);
      check("t6_pc_hold",  bus.oIR_PC,         32'h0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
